// File: rtl/lbp_pkg.sv
// Shared constants, FSM state type and border test for the LBP host memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbp_pkg;

  localparam int IMG_W      = 128;
  localparam int LOG_W      = $clog2(IMG_W);
  localparam int AW         = 2 * LOG_W;
  localparam int DW         = 8;
  localparam int NPIX       = IMG_W * IMG_W;
  localparam int EXP_WRITES = (IMG_W - 2) * (IMG_W - 2);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DUMP  = 2'd2
  } state_t;

  // True when {row,col} lies on the outer ring of the image.
  function automatic logic is_border(input logic [AW-1:0] a);
    logic [LOG_W-1:0] row;
    logic [LOG_W-1:0] col;
    row = a[AW-1:LOG_W];
    col = a[LOG_W-1:0];
    return (row == '0) || (col == '0) || (row == '1) || (col == '1);
  endfunction

endpackage

// File: rtl/lbp_dp_ram.sv
// Image-sized storage: one synchronous write port, one asynchronous read port.
// Latency: write lands at the clock edge; read data is combinational from rd_addr.
// Backpressure: none; every write and read is accepted.
module lbp_dp_ram
  import lbp_pkg::*;
#(
  parameter int RAM_AW = AW,
  parameter int RAM_DW = DW
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] wr_addr,
  input  logic [RAM_DW-1:0] wr_data,
  input  logic [RAM_AW-1:0] rd_addr,
  output logic [RAM_DW-1:0] rd_data
);

  logic [RAM_DW-1:0] mem [2**RAM_AW];

  // Contents are deliberately not reset; they are always rewritten before use.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lbp_host_mem.sv
// Image loader, zero-wait gray read server and LBP result collector/dumper.
// Latency: gray_data same cycle as gray_addr; results stream one beat per cycle.
// Backpressure: out_ready stalls the dump (beat held); ld_ready low outside LOAD.
module lbp_host_mem
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [DW-1:0] gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [DW-1:0] lbp_data,
  input  logic          finish,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          err,
  output logic          done
);

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] ld_cnt;
  logic [AW-1:0] dump_cnt;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] wr_cnt_inc;
  logic [NPIX-1:0] vld;
  logic [DW-1:0] img_rd;
  logic [DW-1:0] res_rd;
  logic          ld_hs;
  logic          ld_last;
  logic          lbp_wr;
  logic          fin;
  logic          out_hs;
  logic          dump_last;

  // Each strobe is qualified by the state that owns it; others are ignored.
  assign ld_hs     = (state == LOAD) && ld_valid;
  assign ld_last   = ld_hs && (ld_cnt == LAST_ADDR);
  assign lbp_wr    = (state == SERVE) && lbp_valid;
  assign fin       = (state == SERVE) && finish;
  assign out_hs    = (state == DUMP) && out_ready;
  assign dump_last = out_hs && (dump_cnt == LAST_ADDR);

  // Saturating write count including any write in the current cycle, so a
  // write coincident with finish is counted.
  assign wr_cnt_inc = (lbp_wr && (wr_cnt != '1)) ? wr_cnt + AW'(1) : wr_cnt;

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt  = state;
    ld_ready   = 1'b0;
    gray_ready = 1'b0;
    out_valid  = 1'b0;
    case (state)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_last) state_nxt = SERVE;
      end
      SERVE: begin
        gray_ready = 1'b1;
        if (fin) state_nxt = DUMP;
      end
      DUMP: begin
        out_valid = 1'b1;
        if (dump_last) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  // State register, counters, sticky error and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= LOAD;
      ld_cnt   <= '0;
      dump_cnt <= '0;
      wr_cnt   <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= dump_last;

      if (dump_last) begin
        ld_cnt <= '0;
      end else if (ld_hs) begin
        ld_cnt <= ld_cnt + AW'(1);
      end

      if (ld_last) begin
        wr_cnt <= '0;
      end else if (lbp_wr) begin
        wr_cnt <= wr_cnt_inc;
      end

      if (fin) begin
        dump_cnt <= '0;
        if (wr_cnt_inc != AW'(EXP_WRITES)) err <= 1'b1;
      end else if (out_hs) begin
        dump_cnt <= dump_cnt + AW'(1);
      end
    end
  end

  // Result-valid bitmap: wiped when a new image becomes resident.
  always_ff @(posedge clk) begin
    if (ld_last) begin
      vld <= '0;
    end else if (lbp_wr) begin
      vld[lbp_addr] <= 1'b1;
    end
  end

  lbp_dp_ram u_img (
    .clk     (clk),
    .we      (ld_hs),
    .wr_addr (ld_cnt),
    .wr_data (ld_data),
    .rd_addr (gray_addr),
    .rd_data (img_rd)
  );

  lbp_dp_ram u_res (
    .clk     (clk),
    .we      (lbp_wr),
    .wr_addr (lbp_addr),
    .wr_data (lbp_data),
    .rd_addr (dump_cnt),
    .rd_data (res_rd)
  );

  assign gray_data = ((state == SERVE) && gray_req) ? img_rd : '0;
  assign out_addr  = (state == DUMP) ? dump_cnt : '0;
  assign out_data  = ((state == DUMP) && !is_border(dump_cnt) && vld[dump_cnt])
                     ? res_rd : '0;

endmodule

// File: doc/lbp_host_mem.md
# lbp_host_mem

Image-memory responder and result collector on the far side of the LBP engine's gray/lbp interface. Accepts a 128×128 8-bit grayscale image over a load stream and serves the engine's `gray_addr`/`gray_req` reads with zero-latency data. Captures every `lbp_valid` write into a result buffer. On `finish` it streams the full 128×128 result map out, with border pixels forced to 0.

## Interface
- `IMG_W`, 128: image width and height in pixels (square, power of two)
- `AW`, 14: address width, `{row[6:0], col[6:0]}`; equals 2·log2(`IMG_W`)
- `DW`, 8: pixel and LBP code width
- `clk` in 1: clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `ld_valid` in 1: load-stream pixel valid
- `ld_data` in DW: load pixel, raster order starting at address 0
- `ld_ready` out 1: load stream accepts a pixel
- `gray_ready` out 1: image resident, engine may start
- `gray_req` in 1: engine read request
- `gray_addr` in AW: engine read address
- `gray_data` out DW: pixel at `gray_addr`
- `lbp_valid` in 1: engine result write strobe
- `lbp_addr` in AW: result address
- `lbp_data` in DW: LBP code
- `finish` in 1: engine completion
- `out_valid` out 1: result-stream beat valid
- `out_ready` in 1: downstream accepts a beat
- `out_addr` out AW: result address of the current beat
- `out_data` out DW: result code of the current beat
- `err` out 1: sticky; write count mismatch detected at `finish`
- `done` out 1: one-cycle pulse after the last result beat

## Operation
- States: LOAD → SERVE → DUMP → LOAD.
- LOAD:
  - `ld_ready`=1.
  - Each `ld_valid&&ld_ready` writes `img[ld_cnt]` and increments `ld_cnt`.
  - The handshake at `ld_cnt`=`IMG_W²`−1 moves to SERVE and clears `wr_cnt` and the result-valid bitmap.
- SERVE:
  - `gray_ready`=1.
  - `gray_data`=`img[gray_addr]` combinationally while `gray_req`=1; otherwise 0.
  - `lbp_valid` writes `res[lbp_addr]`=`lbp_data` and sets `vld[lbp_addr]`. A repeat address is overwritten: last write wins, and `wr_cnt` still increments (saturating 14-bit).
  - `finish`=1 moves to DUMP and resets `dump_cnt`. `err` is set if `wr_cnt` ≠ (`IMG_W`−2)² (15876), counting the same-cycle write if `lbp_valid` and `finish` coincide.
- DUMP:
  - `out_valid`=1, `out_addr`=`dump_cnt`.
  - `out_data`=0 if row or col is 0 or `IMG_W`−1, or if `vld[dump_cnt]`=0; otherwise `res[dump_cnt]`.
  - Advance on `out_valid&&out_ready`. The handshake at `dump_cnt`=`IMG_W²`−1 pulses `done` and returns to LOAD with `ld_cnt`=0.
- Inputs ignored in non-owning states:
  - `ld_valid` outside LOAD.
  - `lbp_valid`, `gray_req` and `finish` outside SERVE.
- `err` clears only on reset.

## Timing
- Reset values:
  - state=LOAD, `ld_ready`=1, `gray_ready`=0, `gray_data`=0
  - `out_valid`=0, `out_addr`=0, `out_data`=0
  - `err`=0, `done`=0, all counters 0
- Reset does not clear `img`/`res`. The `vld` bitmap is cleared on entry to SERVE.
- Reset mid-operation aborts any state. The next cycle is LOAD with `ld_cnt`=0.
- Load:
  - `gray_ready` rises the cycle after the final load handshake.
  - `ld_ready` falls in that same cycle.
- Reads: `gray_data` is valid in the same cycle as `gray_addr`, with no wait states. The engine samples it at the following edge.
- Writes: `res` is updated at the edge where `lbp_valid`=1. Write-to-readback is not required within SERVE.
- Finish: `gray_ready` falls and `out_valid` rises the cycle after `finish` is sampled.
- Dump:
  - Back-to-back beats when `out_ready` is held high; the full dump takes exactly `IMG_W²` cycles.
  - `out_addr`/`out_data` stay stable while `out_valid&&!out_ready`.
- `done`: high for one cycle, coincident with the first LOAD cycle.

## Structure
- Shared package `lbp_pkg`:
  - `IMG_W`, `AW`, `DW`
  - state enum {LOAD, SERVE, DUMP}
  - `EXP_WRITES`=(`IMG_W`−2)²
  - border-test function on `{row,col}`
- One sub-module, `lbp_dp_ram`: `IMG_W²`×`DW`, 1 synchronous write port, 1 asynchronous read port. Instantiated twice: `img` (read by `gray_addr`) and `res` (read by `dump_cnt`).
- The `vld` bitmap, counters and FSM stay in the top.

## Test plan
- Load ramp `img[a]`=a[7:0], then sweep `gray_req` over addresses 0, 129, 16383 → `gray_data` = 0x00, 0x81, 0xFF in the same cycle.
- Load an all-0x10 image. Engine model writes 15876 interior codes of 0xFF, then `finish` → dump shows 0xFF interior, 0x00 on all 508 border pixels, `err`=0, `done` pulses after beat 16383.
- Same flow with only 15875 writes → `err`=1 after `finish`, and the missing address dumps as 0x00.
- Dump with `out_ready` toggling 1,0,0,1 → each beat is held stable and none is lost or duplicated. `addr` increases strictly 0..16383.
- `reset` asserted mid-DUMP at beat 500 → next cycle `out_valid`=0, `ld_ready`=1, `err`=0. A reload and rerun completes normally.
- `lbp_valid` with `lbp_addr`=130 twice (0x11, then 0x22), and `lbp_valid`/`finish` asserted during LOAD → dump `addr` 130 = 0x22. The LOAD-phase strobes have no effect.
